fir_main: RTL and testbench

- Sequential single-MAC FIR engine. Computes the full linear convolution y[n] = sum over k of h[k]*x[n-k] in Q1.15 arithmetic.
- Coefficients and input samples are read from external synchronous RAMs. Results are written to an output RAM through shared address/write strobes.
- Mux-select outputs hand RAM ownership between the host/CDC side and the filter.

---
 rtl/fir_pkg.sv | 37 +++
 rtl/fir_mac.sv | 46 ++++
 rtl/ram.sv | 23 ++
 rtl/fir_main.sv | 144 ++++++++++++++
 tb/tb_fir_main.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM states and tap helpers for the FIR engine
package fir_pkg;

    localparam int DATA_W  = 16;
    localparam int COEF_AW = 5;
    localparam int SAMP_AW = 13;
    localparam int RES_W   = 21;
    localparam int FRAC    = 15;
    localparam int NCOEF_W = 6;
    localparam int NSAMP_W = 14;
    localparam int NOUT_W  = 15;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } fir_state_e;

    // True when sample index n-k lies inside 0..m-1; n-k < 0 shows up as a borrow into bit 15.
    function automatic logic tap_valid(input logic [NOUT_W-1:0]  n,
                                       input logic [COEF_AW-1:0] k,
                                       input logic [NSAMP_W-1:0] m);
        logic [NOUT_W:0] diff;
        diff = {1'b0, n} - {{(NOUT_W+1-COEF_AW){1'b0}}, k};
        return !diff[NOUT_W] && (diff[NOUT_W-1:0] < {1'b0, m});
    endfunction

    // Sample RAM address for tap k of output n; wraps modulo the RAM size for invalid taps.
    function automatic logic [SAMP_AW-1:0] tap_addr(input logic [NOUT_W-1:0]  n,
                                                    input logic [COEF_AW-1:0] k);
        return SAMP_AW'(n - {{(NOUT_W-COEF_AW){1'b0}}, k});
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - Q1.15 multiply, floor shift and 21-bit wrapping accumulator
module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [DATA_W-1:0]        coef_i,
    input  logic [DATA_W-1:0]        samp_i,
    output logic signed [RES_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] coef_ext;
    logic signed [2*DATA_W-1:0] samp_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [RES_W-1:0]    term;
    logic signed [RES_W-1:0]    acc_q;
    logic signed [RES_W-1:0]    acc_d;

    // Full-precision product; the >>> keeps floor rounding and the cast sign-extends the 17-bit term.
    always_comb begin
        coef_ext = {{DATA_W{coef_i[DATA_W-1]}}, coef_i};
        samp_ext = {{DATA_W{samp_i[DATA_W-1]}}, samp_i};
        prod     = coef_ext * samp_ext;
        term     = RES_W'(prod >>> FRAC);
        acc_d    = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + term;
        end
    end

    // Accumulator register; clear wins over a coincident enable.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ram.sv
// rtl/ram.sv - single-port synchronous RAM with registered read
module ram #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] adres,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] pamiec_RAM [0:(1<<ADDR_WIDTH)-1];

    // Write on strobe; read port returns the pre-write contents of the addressed word.
    always_ff @(posedge clk) begin
        if (wr) begin
            pamiec_RAM[adres] <= data;
        end
        data_out <= pamiec_RAM[adres];
    end

endmodule

// File: rtl/fir_main.sv
// rtl/fir_main.sv - sequential single-MAC FIR engine with RAM hand-off control
module fir_main
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCOEF_W-1:0]        f_ile_wsp,
    input  logic [NSAMP_W-1:0]        f_ile_probek,
    input  logic [NOUT_W-1:0]         f_ile_razy,
    input  logic [DATA_W-1:0]         f_wsp_data,
    input  logic [DATA_W-1:0]         f_probka,
    input  logic                      f_start,
    output logic [COEF_AW-1:0]        f_adress_fir,
    output logic [SAMP_AW-1:0]        f_a_probki_fir,
    output logic                      f_fsm_mux_cdc,
    output logic                      f_fsm_mux_wej,
    output logic                      f_fsm_mux_wyj,
    output logic                      f_pracuje,
    output logic                      f_done,
    output logic [RES_W-1:0]          f_fir_probka_wynik,
    output logic                      f_fsm_wyj_wr
);

    fir_state_e           state_q, state_d;
    logic [NOUT_W-1:0]    n_q, n_d;
    logic [COEF_AW-1:0]   k_q, k_d;
    logic [NCOEF_W-1:0]   nn_q, nn_d;
    logic [NSAMP_W-1:0]   mm_q, mm_d;
    logic [NOUT_W-1:0]    ll_q, ll_d;
    logic                 valid_q, valid_d;
    logic [RES_W-1:0]     res_q, res_d;
    logic                 mac_clr;
    logic signed [RES_W-1:0] acc;
    logic                 busy;

    // Returning RAM data lines up with the valid flag registered with its address.
    fir_mac u_mac (
        .clk    (clk),
        .rst_ni (rst_n),
        .clr_i  (mac_clr),
        .en_i   (valid_q),
        .coef_i (f_wsp_data),
        .samp_i (f_probka),
        .acc_o  (acc)
    );

    // State, counters, latched sizes and the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            nn_q    <= '0;
            mm_q    <= '0;
            ll_q    <= '0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            nn_q    <= nn_d;
            mm_q    <= mm_d;
            ll_q    <= ll_d;
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    // Next-state logic and all outputs; addresses are driven only while the filter owns the RAMs.
    always_comb begin
        state_d            = state_q;
        n_d                = n_q;
        k_d                = k_q;
        nn_d               = nn_q;
        mm_d               = mm_q;
        ll_d               = ll_q;
        valid_d            = 1'b0;
        res_d              = res_q;
        mac_clr            = 1'b0;
        busy               = 1'b0;
        f_adress_fir       = '0;
        f_a_probki_fir     = '0;
        f_fsm_wyj_wr       = 1'b0;
        f_done             = 1'b0;
        f_fir_probka_wynik = res_q;

        case (state_q)
            IDLE: begin
                if (f_start) begin
                    nn_d    = f_ile_wsp;
                    mm_d    = f_ile_probek;
                    ll_d    = f_ile_razy;
                    n_d     = '0;
                    state_d = (f_ile_razy == '0) ? DONE : CLR;
                end
            end
            CLR: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
                k_d     = '0;
                state_d = RD;
            end
            RD: begin
                busy           = 1'b1;
                f_adress_fir   = k_q;
                f_a_probki_fir = tap_addr(n_q, k_q);
                valid_d        = tap_valid(n_q, k_q, mm_q);
                k_d            = k_q + 1'b1;
                if (({1'b0, k_q} + 1'b1) >= nn_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = WR;
            end
            WR: begin
                busy               = 1'b1;
                f_fsm_wyj_wr       = 1'b1;
                f_a_probki_fir     = n_q[SAMP_AW-1:0];
                f_fir_probka_wynik = acc;
                res_d              = acc;
                n_d                = n_q + 1'b1;
                state_d            = ((n_q + 1'b1) == ll_q) ? DONE : CLR;
            end
            DONE: begin
                f_done = 1'b1;
                if (!f_start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        f_pracuje     = busy;
        f_fsm_mux_cdc = busy;
        f_fsm_mux_wej = busy;
        f_fsm_mux_wyj = busy;
    end

endmodule

// File: tb/tb_fir_main.sv
// tb/tb_fir_main.sv - randomized and directed self-checking bench for fir_main
module tb_fir_main;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  f_ile_wsp;
    logic [13:0] f_ile_probek;
    logic [14:0] f_ile_razy;
    logic [15:0] f_wsp_data;
    logic [15:0] f_probka;
    logic        f_start;
    logic [4:0]  f_adress_fir;
    logic [12:0] f_a_probki_fir;
    logic        f_fsm_mux_cdc;
    logic        f_fsm_mux_wej;
    logic        f_fsm_mux_wyj;
    logic        f_pracuje;
    logic        f_done;
    logic [20:0] f_fir_probka_wynik;
    logic        f_fsm_wyj_wr;
    logic [12:0] host_addr;
    logic [12:0] out_addr;
    logic [15:0] out_rd;

    int checks = 0;
    int errors = 0;
    int h [0:31];
    int x [0:63];

    always #5 clk = ~clk;

    fir_main dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .f_ile_wsp          (f_ile_wsp),
        .f_ile_probek       (f_ile_probek),
        .f_ile_razy         (f_ile_razy),
        .f_wsp_data         (f_wsp_data),
        .f_probka           (f_probka),
        .f_start            (f_start),
        .f_adress_fir       (f_adress_fir),
        .f_a_probki_fir     (f_a_probki_fir),
        .f_fsm_mux_cdc      (f_fsm_mux_cdc),
        .f_fsm_mux_wej      (f_fsm_mux_wej),
        .f_fsm_mux_wyj      (f_fsm_mux_wyj),
        .f_pracuje          (f_pracuje),
        .f_done             (f_done),
        .f_fir_probka_wynik (f_fir_probka_wynik),
        .f_fsm_wyj_wr       (f_fsm_wyj_wr)
    );

    ram #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) u_coef (
        .clk(clk), .wr(1'b0), .adres(f_adress_fir), .data(16'h0000), .data_out(f_wsp_data)
    );
    ram #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) u_samp (
        .clk(clk), .wr(1'b0), .adres(f_a_probki_fir), .data(16'h0000), .data_out(f_probka)
    );

    assign out_addr = f_fsm_mux_wyj ? f_a_probki_fir : host_addr;

    ram #(.ADDR_WIDTH(13), .DATA_WIDTH(16)) u_out (
        .clk(clk), .wr(f_fsm_wyj_wr), .adres(out_addr), .data(f_fir_probka_wynik[15:0]), .data_out(out_rd)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // y[n] = sum h[k]*x[n-k], each product floored to Q1.15, sum wrapped to 21 bits.
    function automatic int model_y(input int n, input int nn, input int mm);
        int s;
        logic signed [20:0] w;
        s = 0;
        for (int k = 0; k < nn; k++) begin
            if (n - k >= 0 && n - k < mm) begin
                s += (h[k] * x[n - k]) >>> 15;
            end
        end
        w = s[20:0];
        return int'(w);
    endfunction

    task automatic load(input int mm);
        logic [15:0] v;
        for (int k = 0; k < 32; k++) begin
            v = h[k][15:0];
            u_coef.pamiec_RAM[k] = v;
        end
        for (int i = 0; i < 64; i++) begin
            v = (i < mm) ? x[i][15:0] : 16'($urandom);
            u_samp.pamiec_RAM[i] = v;
        end
        for (int i = 8160; i < 8192; i++) begin
            u_samp.pamiec_RAM[i] = 16'($urandom);
        end
    endtask

    task automatic run_case(input string name, input int nn, input int mm, input int ll, input bit toggle);
        int cyc;
        int nw;
        int budget;
        int last;
        bit seen_done;
        logic [15:0] lo;
        cyc = 0; nw = 0; last = 0; seen_done = 1'b0;
        budget = (ll + 1) * (nn + 3) + 20;
        load(mm);
        f_ile_wsp    = nn[5:0];
        f_ile_probek = mm[13:0];
        f_ile_razy   = ll[14:0];
        f_start      = 1'b1;
        while (!seen_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (f_fsm_wyj_wr) begin
                if (nw < ll) begin
                    check({name, " wr_addr"}, int'(f_a_probki_fir), nw);
                    check({name, " wr_data"}, int'($signed(f_fir_probka_wynik)), model_y(nw, nn, mm));
                    check({name, " wr_time"}, cyc, (nw + 1) * (nn + 3));
                    last = model_y(nw, nn, mm);
                end
                nw++;
            end
            if (f_done) seen_done = 1'b1;
            else if (toggle) f_start = 1'($urandom_range(0, 1));
        end
        check({name, " done"}, int'(seen_done), 1);
        check({name, " n_writes"}, nw, ll);
        check({name, " done_status"},
              int'({f_pracuje, f_fsm_mux_cdc, f_fsm_mux_wej, f_fsm_mux_wyj, f_fsm_wyj_wr}), 0);
        if (ll > 0) check({name, " hold"}, int'($signed(f_fir_probka_wynik)), last);
        f_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, " back_idle"}, int'(f_done), 0);
        for (int i = 0; i < ll && i < 6; i++) begin
            host_addr = 13'(i);
            @(negedge clk);
            lo = model_y(i, nn, mm) & 16'hFFFF;
            check({name, " out_ram"}, int'(out_rd), int'(lo));
        end
    endtask

    initial begin
        int nn;
        int mm;
        rst_n = 1'b0; f_start = 1'b0; host_addr = '0;
        f_ile_wsp = '0; f_ile_probek = '0; f_ile_razy = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              int'({f_adress_fir, f_a_probki_fir, f_fsm_mux_cdc, f_fsm_mux_wej, f_fsm_mux_wyj,
                    f_pracuje, f_done, f_fir_probka_wynik, f_fsm_wyj_wr} != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 32; k++) h[k] = 0;
        h[0] = 16384; h[1] = 16384;
        x[0] = -1000; x[1] = -2000; x[2] = -3000; x[3] = -4000;
        run_case("average", 2, 4, 5, 1'b0);

        h[0] = -32768; h[1] = 0;
        x[0] = 1000; x[1] = -2000; x[2] = 3000; x[3] = -4000;
        run_case("negate", 1, 4, 4, 1'b0);

        h[0] = 0; h[1] = -32768;
        x[0] = 1000; x[1] = 2000; x[2] = 3000; x[3] = 4000;
        run_case("delay", 2, 4, 5, 1'b0);

        h[0] = 16384; h[1] = 16384; h[2] = 16384;
        x[0] = 8192; x[1] = 8192; x[2] = 8192;
        run_case("three_tap", 3, 3, 5, 1'b1);

        h[0] = -32768; x[0] = -32768;
        run_case("headroom", 1, 1, 1, 1'b0);
        check("headroom_value", int'(f_fir_probka_wynik), 32768);

        run_case("l_zero", 3, 3, 0, 1'b0);

        // Abort during RD, then a fresh run must start again from n=0.
        for (int k = 0; k < 32; k++) h[k] = $urandom_range(0, 65535) - 32768;
        for (int i = 0; i < 64; i++) x[i] = $urandom_range(0, 65535) - 32768;
        load(6);
        f_ile_wsp = 6'd5; f_ile_probek = 14'd6; f_ile_razy = 15'd10; f_start = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", int'(f_pracuje), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs",
              int'({f_adress_fir, f_a_probki_fir, f_fsm_mux_cdc, f_fsm_mux_wej, f_fsm_mux_wyj,
                    f_pracuje, f_done, f_fir_probka_wynik, f_fsm_wyj_wr} != '0), 0);
        f_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", int'(f_fsm_wyj_wr | f_pracuje), 0);
        run_case("after_reset", 5, 6, 10, 1'b0);

        for (int t = 0; t < 8; t++) begin
            nn = $urandom_range(1, 32);
            mm = $urandom_range(1, 24);
            for (int k = 0; k < 32; k++) begin
                h[k] = ($urandom_range(0, 7) == 0) ? -32768 : $urandom_range(0, 65535) - 32768;
            end
            for (int i = 0; i < 64; i++) begin
                x[i] = ($urandom_range(0, 7) == 0) ? -32768 : $urandom_range(0, 65535) - 32768;
            end
            run_case($sformatf("rand%0d", t), nn, mm, nn + mm - 1, t[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
